// File: rtl/subleq_pkg.sv
// Shared definitions for the subleq memory/I-O subsystem.
//   state_t            : subsystem sequencing state (LOAD -> RUN -> HALT)
//   DEFAULT_BITS       : default word/address width
//   DEFAULT_FIFO_DEPTH : default output FIFO depth
//   out_addr_default   : top-but-one address, used as the output port
//   halt_addr_default  : top address, used as the halt trigger
package subleq_pkg;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    localparam int DEFAULT_BITS       = 8;
    localparam int DEFAULT_FIFO_DEPTH = 4;

    function automatic int out_addr_default(input int bits);
        return (2 ** bits) - 2;
    endfunction

    function automatic int halt_addr_default(input int bits);
        return (2 ** bits) - 1;
    endfunction

endpackage

// File: rtl/subleq_memory_if.sv
// Stream handshakes of the subleq memory subsystem.
//   load_* : program-load stream into the memory (valid/ready, with last)
//   out_*  : output-port stream out of the memory (valid/ready)
// master : the producer of program words and consumer of output words
// slave  : the memory subsystem
interface subleq_memory_if #(
    parameter int BITS = 8
);
    logic            load_valid;
    logic            load_ready;
    logic [BITS-1:0] load_data;
    logic            load_last;

    logic            out_valid;
    logic            out_ready;
    logic [BITS-1:0] out_data;

    modport master (
        output load_valid, load_data, load_last, out_ready,
        input  load_ready, out_valid, out_data
    );

    modport slave (
        input  load_valid, load_data, load_last, out_ready,
        output load_ready, out_valid, out_data
    );
endinterface

// File: rtl/subleq_out_fifo.sv
// Synchronous FIFO behind the CPU's output port.
//   clock, reset : posedge clock, synchronous active-high reset
//   push/push_data : enqueue; accepted when not full, or when full with a pop
//   pop/pop_data   : dequeue; pop_data is the current head (first-word fall-through)
//   full, empty    : occupancy flags
// DEPTH must be a power of two >= 2 so pointers wrap naturally.
module subleq_out_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] storage [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push_ok;
    logic             pop_ok;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign pop_data = storage[rd_ptr];

    // When full, a simultaneous pop frees the head slot, which is exactly
    // where wr_ptr points, so the push can land there on the same edge.
    assign push_ok  = push && (!full || pop);
    assign pop_ok   = pop && !empty;

    always_ff @(posedge clock) begin
        if (push_ok) begin
            storage[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/subleq_memory.sv
// Memory and I/O subsystem on the subleq CPU's single-port bus.
// Loads a program from the load stream while holding the CPU in reset,
// releases the CPU, serves zero-latency reads and accepts writes, and maps
// an output FIFO port and a halt trigger into the address space.
//   clock, reset : posedge clock, synchronous active-high reset
//   cpu_reset    : CPU reset, high in LOAD and HALT
//   cpu_write    : CPU write strobe
//   cpu_address  : CPU address
//   cpu_data     : bidirectional data; driven by this block only in RUN reads
//   bus          : load stream (in) and output stream (out)
//   overflow     : sticky, an output word was dropped because the FIFO was full
//   halted       : subsystem is in HALT
//
// state | meaning
// LOAD  | accepting program words, CPU held in reset
// RUN   | CPU running, bus served
// HALT  | CPU stopped by a halt write; left only through reset
module subleq_memory
    import subleq_pkg::*;
#(
    parameter int              BITS       = DEFAULT_BITS,
    parameter int              DEPTH      = 2 ** BITS,
    parameter logic [BITS-1:0] OUT_ADDR   = BITS'(out_addr_default(BITS)),
    parameter logic [BITS-1:0] HALT_ADDR  = BITS'(halt_addr_default(BITS)),
    parameter int              FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic            clock,
    input  logic            reset,
    output logic            cpu_reset,
    input  logic            cpu_write,
    input  logic [BITS-1:0] cpu_address,
    inout  wire  [BITS-1:0] cpu_data,
    subleq_memory_if.slave  bus,
    output logic            overflow,
    output logic            halted
);
    localparam int ADDR_W = $clog2(DEPTH);

    state_t            state;
    logic [ADDR_W-1:0] load_addr;
    logic              load_ready;

    logic [BITS-1:0]   mem [DEPTH];
    logic [ADDR_W-1:0] mem_idx;
    logic              in_range;
    logic [BITS-1:0]   rd_data;

    logic              load_fire;
    logic              load_done;
    logic              cpu_we;
    logic              out_push;
    logic              halt_hit;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;

    assign bus.load_ready = load_ready;
    assign bus.out_valid  = !fifo_empty;

    assign load_fire = bus.load_valid && load_ready && !reset;
    assign load_done = load_fire &&
                       (bus.load_last || (load_addr == ADDR_W'(DEPTH - 1)));

    assign cpu_we    = (state == ST_RUN) && cpu_write;
    assign out_push  = cpu_we && (cpu_address == OUT_ADDR);
    assign halt_hit  = cpu_we && (cpu_address == HALT_ADDR);
    assign fifo_pop  = bus.out_valid && bus.out_ready;

    // Addresses beyond the RAM read as zero and are not stored, but the
    // I/O decode above still sees them.
    assign in_range  = (int'(cpu_address) < DEPTH);
    assign mem_idx   = cpu_address[ADDR_W-1:0];
    assign rd_data   = in_range ? mem[mem_idx] : '0;

    // The CPU samples read data on the same edge it presents the address,
    // so the read path is purely combinational.
    assign cpu_data  = ((state == ST_RUN) && !cpu_write) ? rd_data : {BITS{1'bz}};

    // RAM is deliberately not reset so a program survives a CPU restart.
    always_ff @(posedge clock) begin
        if (load_fire) begin
            mem[load_addr] <= bus.load_data;
        end else if (cpu_we && in_range) begin
            mem[mem_idx] <= cpu_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_LOAD;
            load_addr  <= '0;
            load_ready <= 1'b1;
            cpu_reset  <= 1'b1;
            halted     <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            case (state)
                ST_LOAD: begin
                    if (load_fire) begin
                        load_addr <= load_addr + 1'b1;
                    end
                    if (load_done) begin
                        state      <= ST_RUN;
                        load_ready <= 1'b0;
                        cpu_reset  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (halt_hit) begin
                        state     <= ST_HALT;
                        cpu_reset <= 1'b1;
                        halted    <= 1'b1;
                    end
                end
                ST_HALT: begin
                    state <= ST_HALT;
                end
                default: begin
                    state      <= ST_LOAD;
                    load_addr  <= '0;
                    load_ready <= 1'b1;
                    cpu_reset  <= 1'b1;
                    halted     <= 1'b0;
                end
            endcase

            // The CPU cannot stall, so a push into a full FIFO without a
            // concurrent pop is lost and flagged until the next reset.
            if (out_push && fifo_full && !fifo_pop) begin
                overflow <= 1'b1;
            end
        end
    end

    subleq_out_fifo #(
        .WIDTH (BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_out_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (out_push),
        .push_data (cpu_data),
        .pop       (fifo_pop),
        .pop_data  (bus.out_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule
